// File: rtl/coef_bank_writer_if.sv
// ---------------------------------------------------------------------------
// coef_bank_writer_if
// Groups the coefficient stream, request pulses and bank outputs of
// coef_bank_writer into one bundle.
//   start, bypass_req : one-cycle requests (load / filter bypass)
//   coef_data/valid   : coefficient stream into the writer
//   coef_ready        : writer accepts coef_data this cycle
//   coef_mux          : bank-select code to the parameter control block
//   parameter_out[k]  : bank word for slot k (0..9)
//   busy, done        : status; done pulses when a whole load has committed
// master = stream source / controller, slave = coef_bank_writer.
// ---------------------------------------------------------------------------
interface coef_bank_writer_if;
    logic              start;
    logic              bypass_req;
    logic [31:0]       coef_data;
    logic              coef_valid;
    logic              coef_ready;
    logic [31:0]       coef_mux;
    logic [9:0][31:0]  parameter_out;
    logic              busy;
    logic              done;

    modport master (
        output start, bypass_req, coef_data, coef_valid,
        input  coef_ready, coef_mux, parameter_out, busy, done
    );

    modport slave (
        input  start, bypass_req, coef_data, coef_valid,
        output coef_ready, coef_mux, parameter_out, busy, done
    );
endinterface

// File: rtl/coef_bank_writer.sv
// ---------------------------------------------------------------------------
// coef_bank_writer
// Streams NUM_COEF coefficients into a 10-slot shadow bank and commits each
// full (or final partial) bank to parameter_out while driving the bank number
// on coef_mux for COMMIT_CYCLES cycles. A bypass request drives code 0 for a
// single cycle. HOLD_CODE is the idle bank-select code.
// Ports:
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : coef_bank_writer_if.slave (stream, requests, bank outputs)
// ---------------------------------------------------------------------------
module coef_bank_writer #(
    parameter int NUM_COEF      = 33,
    parameter int COMMIT_CYCLES = 2,
    parameter int HOLD_CODE     = 15
) (
    input  logic                clk,
    input  logic                reset_n,
    coef_bank_writer_if.slave   bus
);
    localparam logic [5:0]  LAST_TOTAL  = 6'(NUM_COEF - 1);
    localparam logic [5:0]  FULL_TOTAL  = 6'(NUM_COEF);
    localparam logic [3:0]  LAST_COMMIT = 4'(COMMIT_CYCLES - 1);
    localparam logic [31:0] HOLD_WORD   = 32'(HOLD_CODE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BYPASS,
        ST_COLLECT,
        ST_COMMIT
    } state_t;

    state_t      state_q;
    logic [3:0]  slot_q;        // 0..10
    logic [5:0]  total_q;       // 0..40
    logic [2:0]  bank_q;        // 1..4
    logic [3:0]  commit_cnt_q;  // 0..14
    logic        coef_ready_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] coef_mux_q;

    logic             accept;
    logic             bank_full;
    logic             commit_last;
    logic             load_complete;
    logic             shadow_clear;
    logic [9:0][31:0] shadow_d;

    // coef_ready is only ever high in COLLECT, so this implies COLLECT.
    assign accept        = coef_ready_q & bus.coef_valid;
    // The acceptance that fills slot 9 or delivers the last word closes the bank.
    assign bank_full     = accept && ((slot_q == 4'd9) || (total_q == LAST_TOTAL));
    assign commit_last   = (state_q == ST_COMMIT) && (commit_cnt_q == LAST_COMMIT);
    assign load_complete = (total_q == FULL_TOTAL);
    assign shadow_clear  = ((state_q == ST_IDLE) && bus.start) ||
                           (commit_last && !load_complete);

    // Per-slot shadow and output registers. shadow_d already contains the word
    // accepted this cycle, so the closing word reaches parameter_out on the
    // same edge that coef_mux takes the bank number.
    for (genvar gi = 0; gi < 10; gi++) begin : g_slot
        logic [31:0] shadow_q;
        logic [31:0] param_q;

        assign shadow_d[gi] = (accept && (slot_q == 4'(gi))) ? bus.coef_data : shadow_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                shadow_q <= '0;
                param_q  <= '0;
            end else begin
                shadow_q <= shadow_clear ? 32'd0 : shadow_d[gi];
                if (bank_full) begin
                    param_q <= shadow_d[gi];
                end
            end
        end

        assign bus.parameter_out[gi] = param_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            slot_q       <= '0;
            total_q      <= '0;
            bank_q       <= '0;
            commit_cnt_q <= '0;
            coef_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            coef_mux_q   <= HOLD_WORD;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // start has priority; a simultaneous bypass_req is dropped.
                    if (bus.start) begin
                        state_q      <= ST_COLLECT;
                        bank_q       <= 3'd1;
                        slot_q       <= '0;
                        total_q      <= '0;
                        coef_ready_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end else if (bus.bypass_req) begin
                        state_q    <= ST_BYPASS;
                        coef_mux_q <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_BYPASS: begin
                    state_q    <= ST_IDLE;
                    coef_mux_q <= HOLD_WORD;
                    busy_q     <= 1'b0;
                end
                ST_COLLECT: begin
                    if (accept) begin
                        slot_q  <= slot_q + 4'd1;
                        total_q <= total_q + 6'd1;
                        if (bank_full) begin
                            state_q      <= ST_COMMIT;
                            coef_ready_q <= 1'b0;
                            coef_mux_q   <= 32'(bank_q);
                            commit_cnt_q <= '0;
                        end
                    end
                end
                ST_COMMIT: begin
                    if (commit_last) begin
                        coef_mux_q <= HOLD_WORD;
                        if (load_complete) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q      <= ST_COLLECT;
                            bank_q       <= bank_q + 3'd1;
                            slot_q       <= '0;
                            coef_ready_q <= 1'b1;
                        end
                    end else begin
                        commit_cnt_q <= commit_cnt_q + 4'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.coef_ready = coef_ready_q;
    assign bus.coef_mux   = coef_mux_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: doc/coef_bank_writer.md
COEF_BANK_WRITER -- requirements
Module: coef_bank_writer

Interface
REQ-001 Parameter NUM_COEF, default 33, total coefficients per load; legal range 1..40.
REQ-002 Parameter COMMIT_CYCLES, default 2, cycles each bank select is held; legal range 1..15.
REQ-003 Parameter HOLD_CODE, default 15, idle bank-select code; SHALL NOT be 0..4.
REQ-004 clk  in  1  single system clock; all logic SHALL be on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle request to begin a coefficient load.
REQ-007 bypass_req  in  1  one-cycle request to put the downstream filter in bypass.
REQ-008 coef_data  in  32  coefficient word, stream order c0..c(NUM_COEF-1).
REQ-009 coef_valid  in  1  coef_data valid.
REQ-010 coef_ready  out  1  block accepts coef_data this cycle.
REQ-011 coef_mux  out  32  bank-select code to the parameter control block.
REQ-012 parameter_out_0..parameter_out_9  out  32 each  bank words, slot k carries coefficient (bank-1)*10+k.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse when the final bank commit ends.

Function
REQ-015 FSM states SHALL be IDLE, BYPASS, COLLECT, COMMIT.
REQ-016 A word SHALL be accepted only on a cycle with coef_valid=1 and coef_ready=1.
REQ-017 coef_ready SHALL be 1 only in COLLECT.
REQ-018 IDLE + start=1 -> COLLECT next cycle; bank=1, slot index=0, total count=0, shadow slots cleared to 0.
REQ-019 IDLE + bypass_req=1 (start=0) -> BYPASS; coef_mux=0 for exactly 1 cycle, then HOLD_CODE, return to IDLE.
REQ-020 start and bypass_req both high in IDLE: start SHALL win and bypass_req SHALL be dropped.
REQ-021 start and bypass_req outside IDLE SHALL be ignored and not queued.
REQ-022 COLLECT: each accepted word SHALL be written to shadow[slot]; slot and total SHALL each increment by 1.
REQ-023 COLLECT -> COMMIT on the acceptance that makes slot=10 or total=NUM_COEF; coef_ready SHALL be 0 the next cycle.
REQ-024 On COMMIT entry, parameter_out_0..9 SHALL take the shadow values and coef_mux SHALL take the bank number, both on the same clock edge.
REQ-025 Unfilled slots of a partial final bank SHALL drive 0.
REQ-026 coef_mux SHALL hold the bank number for exactly COMMIT_CYCLES cycles; parameter_out SHALL be stable throughout.
REQ-027 After COMMIT: coef_mux=HOLD_CODE.
REQ-028 After COMMIT, if total<NUM_COEF: bank+1, slot=0, shadow cleared, -> COLLECT.
REQ-029 After COMMIT, if total=NUM_COEF: done=1 for one cycle, -> IDLE.
REQ-030 parameter_out SHALL retain their last values outside COMMIT.
REQ-031 coef_mux SHALL never take values other than 0, 1..ceil(NUM_COEF/10), or HOLD_CODE; bank 0 SHALL never be driven by a load.
REQ-032 Counters SHALL be sized for NUM_COEF=40 and SHALL NOT wrap.
REQ-033 Minimum load time, back-to-back valid words: NUM_COEF + ceil(NUM_COEF/10)*COMMIT_CYCLES cycles from first acceptance to done; coef_valid gaps SHALL only stretch COLLECT.

Reset
REQ-034 reset_n=0 SHALL immediately force state=IDLE, coef_mux=HOLD_CODE, coef_ready=0, busy=0, done=0, parameter_out_0..9=0, all counters and shadow=0.
REQ-035 Reset mid-load SHALL abandon the load without pulsing done; the next load SHALL restart at bank 1.

Verification
REQ-036 Full load: start, then 33 words 0x100+i back-to-back -> coef_mux sequence 1,1,2,2,3,3,4,4; bank 4 parameter_out_0..2 = 0x11E..0x120, slots 3..9 = 0; done at cycle 33+8.
REQ-037 Bypass: bypass_req in IDLE -> coef_mux=0 for 1 cycle then 15; busy high 1 cycle; start+bypass_req together -> load only.
REQ-038 Stalled stream: coef_valid toggled 1/0 -> identical bank contents to REQ-036; coef_ready never high in COMMIT.
REQ-039 Short load NUM_COEF=10 -> single commit, coef_mux=1 for 2 cycles, done; NUM_COEF=1 -> slot 0 only nonzero.
REQ-040 reset_n low after word 15 -> coef_mux=15 immediately, no done; fresh start -> bank 1 re-driven with new data.
REQ-041 start asserted during COLLECT/COMMIT -> no effect on sequence or counters.
